// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus driver for small combinational blocks: steps x through every
// input code, holds each for HOLD cycles, and captures f_in into a truth table.
module truth_table_sweeper #(
  parameter int N_IN = 3,
  parameter int HOLD = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      x,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        ones_count,
  output logic                 sample_stb
);

  localparam int              CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD - 1);
  localparam logic [N_IN-1:0] X_LAST   = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      x          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_out  <= '0;
      ones_count <= '0;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            x          <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            hold_cnt   <= '0;
            table_out  <= '0;
            ones_count <= '0;
          end
        end
        RUN: begin
          // Sample on the last cycle of the hold window, when f_in has settled.
          if (hold_cnt == CNT_LAST) begin
            table_out[x] <= f_in;
            ones_count   <= ones_count + {{N_IN{1'b0}}, f_in};
            sample_stb   <= 1'b1;
            hold_cnt     <= '0;
            if (x == X_LAST) begin
              x     <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              x <= x + N_IN'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Upstream stimulus stage for the small combinational lab blocks (3-input, single-output functions).
- On `start`, drives every input combination 0..2^N_IN-1 in ascending order and holds each for HOLD cycles.
- Samples the block's output at the end of each hold window and assembles the result into a truth-table register.
- Replaces hand-written exhaustive stimulus sequences and makes the captured function available to a downstream checker.

Parameters:
- N_IN, 3, number of function inputs; vector width (1..6).
- HOLD, 10, clock cycles each vector is held before sampling (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin sweep; sampled only in IDLE or DONE
- x  output  N_IN  stimulus vector to the function under test; x[N_IN-1] is the first input (x1), x[0] is the last (x3)
- f_in  input  1  function output returned from the block under test
- busy  output  1  high while a sweep is in progress
- done  output  1  high once a sweep has completed; held until the next start or rst
- table_out  output  2**N_IN  bit v = f_in captured while x==v
- ones_count  output  N_IN+1  number of 1 bits in table_out
- sample_stb  output  1  one-cycle pulse on each capture

Behaviour:
- Reset: on a clk edge with rst=1, all outputs go to 0 (x, busy, done, table_out, ones_count, sample_stb), state=IDLE, hold counter=0.
- rst has priority over everything, including mid-sweep; the sweep is abandoned and the partial table is cleared.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Next state RUN; x=0, busy=1, done=0, hold_cnt=0.
  - table_out and ones_count cleared.
- RUN:
  - hold_cnt counts 0..HOLD-1; x is stable throughout.
  - At the edge where hold_cnt==HOLD-1:
    - table_out[x] <= f_in
    - ones_count += f_in
    - sample_stb=1 for the following cycle
    - hold_cnt <= 0
  - At that edge, if x != 2^N_IN-1: x <= x+1 and stay in RUN.
  - At that edge, if x == 2^N_IN-1: x <= 0, busy <= 0, done <= 1, next state DONE. x must not wrap to 0 while still in RUN.
- Timing: if start is accepted at edge k, vector v is driven from edge k+v*HOLD and sampled at edge k+(v+1)*HOLD. done rises at edge k+2^N_IN*HOLD (80 cycles for the defaults).
- f_in is sampled exactly once per vector, on the last hold cycle. f_in is treated as synchronous/settled by then; no synchroniser is included.
- start while in RUN is ignored and has no effect on timing.
- DONE: table_out and ones_count are held; start=1 clears done and restarts the sweep exactly as from IDLE.
- HOLD=1: a new vector every cycle and sample_stb high continuously during the sweep.
- ones_count never exceeds 2^N_IN; the width N_IN+1 covers an all-ones table.

Test Plan:
- Reset then idle: rst for 2 cycles, start=0 for 20 cycles -> all outputs 0, x stays 0.
- Full sweep, defaults, f_in = majority(x) driven combinationally from x:
  - x steps 0..7 every 10 cycles.
  - done rises exactly 80 cycles after the start edge.
  - table_out=8'hE8, ones_count=4, 8 sample_stb pulses.
- Start ignored while busy: pulse start again at cycle 35 of the sweep -> identical timing and result to the previous scenario (done at 80, table 8'hE8).
- Reset mid-sweep: rst at cycle 45 -> next edge busy=0, x=0, table_out=0, ones_count=0. A fresh start then completes normally in 80 cycles.
- Restart from DONE with f_in tied 1 -> done drops the cycle after start, then after 80 cycles table_out=8'hFF, ones_count=4'd8.
- HOLD=1, N_IN=2, f_in = XOR of the two inputs -> done 4 cycles after start, table_out=4'b0110, ones_count=2, sample_stb high for 4 consecutive cycles.
